dcache_ctrl: RTL and testbench

Miss-handling controller for the processor's data-memory system: a direct-mapped, write-back, write-allocate cache in front of a fixed-latency word memory. It sits between the memory stage of the pipeline and the cache/memory arrays. It sequences hits, evictions and line fills. Its `CacheHit`/`CacheReq` outputs feed the `DCacheHit`/`DCacheReq` counters of the processor performance bench.

---
 rtl/dcache_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Purpose  : Miss-handling controller for a direct-mapped, write-back,
//            write-allocate data cache. A fixed-latency word memory sits
//            behind the cache. Hits complete in the request cycle. Misses
//            may write back a dirty victim line, then fill the new line and
//            replay the request.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            Addr/DataIn/Rd/Wr   - CPU request (held until Done)
//            DataOut/Done/Stall  - CPU response
//            CacheHit/CacheReq   - performance-counter pulses
//            Err                 - illegal request (odd address or Rd&Wr)
//            c_*                 - cache array control and lookup results
//            m_*                 - word memory request and read data
// Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
    parameter int MEM_LAT = 2            // memory read latency, legal 1..4
) (
    input  logic        clk,
    input  logic        rst,
    // CPU side
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        CacheReq,
    output logic        Err,
    // cache array side
    output logic        c_enable,
    output logic        c_comp,
    output logic        c_write,
    output logic        c_valid_in,
    output logic [7:0]  c_index,
    output logic [2:0]  c_offset,
    output logic [4:0]  c_tag_in,
    output logic [15:0] c_data_in,
    input  logic        c_hit,
    input  logic        c_dirty,
    input  logic        c_valid,
    input  logic [4:0]  c_tag_out,
    input  logic [15:0] c_data_out,
    // memory side
    output logic [15:0] m_addr,
    output logic [15:0] m_data_in,
    output logic        m_rd,
    output logic        m_wr,
    input  logic [15:0] m_data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WB    = 2'd1,
        ALLOC = 2'd2,
        RETRY = 2'd3
    } stateT;

    // Fill of word k lands MEM_LAT cycles after its read; the allocate
    // phase therefore ends on cycle MEM_LAT+3.
    localparam logic [2:0] LAT3       = 3'(MEM_LAT);
    localparam logic [2:0] ALLOC_LAST = 3'(MEM_LAT + 3);

    stateT       r_state;
    logic [2:0]  r_cnt;
    stateT       w_stateNext;
    logic [2:0]  w_cntNext;

    logic [4:0]  w_tag;
    logic [7:0]  w_index;
    logic        w_anyReq;
    logic        w_illegal;
    logic        w_legal;
    logic        w_hit;
    logic [1:0]  w_fillWord;
    logic        w_fillActive;
    logic        w_rdActive;

    assign w_tag     = Addr[15:11];
    assign w_index   = Addr[10:3];
    assign w_anyReq  = Rd | Wr;
    assign w_illegal = (Rd & Wr) | (w_anyReq & Addr[0]);
    assign w_legal   = w_anyReq & ~w_illegal;
    assign w_hit     = c_hit & c_valid;

    // Allocate phase: reads issue on cycles 0..3, fills trail by MEM_LAT.
    // Two-bit wraparound subtraction gives the word being filled.
    assign w_rdActive   = ~r_cnt[2];
    assign w_fillActive = (r_cnt >= LAT3);
    assign w_fillWord   = r_cnt[1:0] - LAT3[1:0];

    // ------------------------------------------------------------------
    // Output and next-state decode. Hits must answer in the request
    // cycle, so the strobes are decoded from the current state and the
    // combinational cache lookup. All outputs are forced low during reset.
    // ------------------------------------------------------------------
    always_comb begin
        DataOut     = 16'h0000;
        Done        = 1'b0;
        Stall       = 1'b0;
        CacheHit    = 1'b0;
        CacheReq    = 1'b0;
        Err         = 1'b0;
        c_enable    = 1'b0;
        c_comp      = 1'b0;
        c_write     = 1'b0;
        c_valid_in  = 1'b0;
        c_index     = 8'h00;
        c_offset    = 3'b000;
        c_tag_in    = 5'b00000;
        c_data_in   = 16'h0000;
        m_addr      = 16'h0000;
        m_data_in   = 16'h0000;
        m_rd        = 1'b0;
        m_wr        = 1'b0;
        w_stateNext = r_state;
        w_cntNext   = r_cnt;

        if (!rst) begin
            case (r_state)
                IDLE: begin
                    w_cntNext = 3'd0;
                    if (w_illegal) begin
                        Err  = 1'b1;
                        Done = 1'b1;
                    end else if (w_legal) begin
                        CacheReq   = 1'b1;
                        c_enable   = 1'b1;
                        c_comp     = 1'b1;
                        c_write    = Wr;
                        c_valid_in = Wr;
                        c_index    = w_index;
                        c_offset   = Addr[2:0];
                        c_tag_in   = w_tag;
                        c_data_in  = DataIn;
                        if (w_hit) begin
                            Done     = 1'b1;
                            CacheHit = 1'b1;
                            DataOut  = Rd ? c_data_out : 16'h0000;
                        end else begin
                            Stall = 1'b1;
                            // A valid dirty victim must be written back
                            // before its slot can be refilled.
                            w_stateNext = (c_valid & c_dirty) ? WB : ALLOC;
                        end
                    end
                end

                WB: begin
                    Stall     = 1'b1;
                    // Direct read of the victim; its resident tag forms
                    // the write-back address.
                    c_enable  = 1'b1;
                    c_index   = w_index;
                    c_offset  = {r_cnt[1:0], 1'b0};
                    m_wr      = 1'b1;
                    m_addr    = {c_tag_out, w_index, r_cnt[1:0], 1'b0};
                    m_data_in = c_data_out;
                    if (r_cnt == 3'd3) begin
                        w_stateNext = ALLOC;
                        w_cntNext   = 3'd0;
                    end else begin
                        w_cntNext = r_cnt + 3'd1;
                    end
                end

                ALLOC: begin
                    Stall = 1'b1;
                    if (w_rdActive) begin
                        m_rd   = 1'b1;
                        m_addr = {w_tag, w_index, r_cnt[1:0], 1'b0};
                    end
                    if (w_fillActive) begin
                        c_enable   = 1'b1;
                        c_write    = 1'b1;
                        c_valid_in = 1'b1;
                        c_index    = w_index;
                        c_offset   = {w_fillWord, 1'b0};
                        c_tag_in   = w_tag;
                        c_data_in  = m_data_out;
                    end
                    if (r_cnt == ALLOC_LAST) begin
                        w_stateNext = RETRY;
                        w_cntNext   = 3'd0;
                    end else begin
                        w_cntNext = r_cnt + 3'd1;
                    end
                end

                RETRY: begin
                    // The line is now resident: the replay hits, and a
                    // store replayed here marks the line dirty.
                    c_enable    = 1'b1;
                    c_comp      = 1'b1;
                    c_write     = Wr;
                    c_valid_in  = Wr;
                    c_index     = w_index;
                    c_offset    = Addr[2:0];
                    c_tag_in    = w_tag;
                    c_data_in   = DataIn;
                    Done        = 1'b1;
                    DataOut     = Rd ? c_data_out : 16'h0000;
                    w_stateNext = IDLE;
                    w_cntNext   = 3'd0;
                end

                default: begin
                    w_stateNext = IDLE;
                    w_cntNext   = 3'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register. Reset abandons any miss in progress; read data
    // still in flight from memory is simply never consumed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Purpose  : Directed self-checking bench for dcache_ctrl with a behavioural
//            cache array and a fixed-latency word memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr, DataIn, DataOut;
    logic        Rd, Wr, Done, Stall, CacheHit, CacheReq, Err;
    logic        c_enable, c_comp, c_write, c_valid_in;
    logic [7:0]  c_index;
    logic [2:0]  c_offset;
    logic [4:0]  c_tag_in;
    logic [15:0] c_data_in;
    logic        c_hit, c_dirty, c_valid;
    logic [4:0]  c_tag_out;
    logic [15:0] c_data_out;
    logic [15:0] m_addr, m_data_in, m_data_out;
    logic        m_rd, m_wr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dcache_ctrl #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst),
        .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall),
        .CacheHit(CacheHit), .CacheReq(CacheReq), .Err(Err),
        .c_enable(c_enable), .c_comp(c_comp), .c_write(c_write),
        .c_valid_in(c_valid_in), .c_index(c_index), .c_offset(c_offset),
        .c_tag_in(c_tag_in), .c_data_in(c_data_in),
        .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid),
        .c_tag_out(c_tag_out), .c_data_out(c_data_out),
        .m_addr(m_addr), .m_data_in(m_data_in), .m_rd(m_rd), .m_wr(m_wr),
        .m_data_out(m_data_out)
    );

    // ---------------- behavioural cache array ----------------
    logic [4:0]  tagArr   [0:255];
    logic        validArr [0:255];
    logic        dirtyArr [0:255];
    logic [15:0] dataArr  [0:1023];

    assign c_valid    = validArr[c_index];
    assign c_dirty    = dirtyArr[c_index];
    assign c_tag_out  = tagArr[c_index];
    assign c_hit      = c_comp & (tagArr[c_index] == c_tag_in);
    assign c_data_out = dataArr[{c_index, c_offset[2:1]}];

    always @(posedge clk) begin
        if (c_enable && c_write) begin
            if (c_comp) begin
                if (c_hit && c_valid) begin
                    dataArr[{c_index, c_offset[2:1]}] <= c_data_in;
                    dirtyArr[c_index] <= 1'b1;
                end
            end else begin
                dataArr[{c_index, c_offset[2:1]}] <= c_data_in;
                tagArr[c_index]   <= c_tag_in;
                validArr[c_index] <= c_valid_in;
                dirtyArr[c_index] <= 1'b0;
            end
        end
    end

    // ---------------- fixed-latency word memory ----------------
    logic [15:0] memArr [0:32767];
    logic [15:0] rdPipe [0:MEM_LAT-1];

    function automatic logic [15:0] memInit(input logic [15:0] a);
        return a ^ 16'hC35A;
    endfunction

    assign m_data_out = memArr[rdPipe[MEM_LAT-1][15:1]];

    always @(posedge clk) begin
        rdPipe[0] <= m_rd ? m_addr : 16'h0000;
        for (int i = 1; i < MEM_LAT; i++) rdPipe[i] <= rdPipe[i-1];
        if (m_wr) memArr[m_addr[15:1]] <= m_data_in;
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            tagArr[i] = 5'd0; validArr[i] = 1'b0; dirtyArr[i] = 1'b0;
        end
        for (int i = 0; i < 1024; i++) dataArr[i] = 16'h0000;
        for (int i = 0; i < 32768; i++) memArr[i] = memInit(16'(i * 2));
        for (int i = 0; i < MEM_LAT; i++) rdPipe[i] = 16'h0000;
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; Rd = 1'b1; Wr = 1'b0; Addr = 16'h0018; DataIn = 16'h0;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({Done, Stall, CacheReq, CacheHit, Err, c_enable, m_rd, m_wr} !== 8'h00) begin
                $display("FAIL reset_outputs: got %b want 00000000",
                         {Done, Stall, CacheReq, CacheHit, Err, c_enable, m_rd, m_wr});
                miscompares++;
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; Rd = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if ({Done, Stall, CacheHit, CacheReq, Err, m_rd, m_wr, c_enable, c_write} !== 9'h000) begin
                $display("FAIL idle_strobes cyc %0d: got %b want 000000000", c,
                         {Done, Stall, CacheHit, CacheReq, Err, m_rd, m_wr, c_enable, c_write});
                miscompares++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_cold_miss();
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h0018;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            vectors++;
            if (CacheReq !== (c == 0) || Done !== (c == 7) || Stall !== (c < 7)) begin
                $display("FAIL cold_ctrl cyc %0d: got req=%b done=%b stall=%b want %b %b %b",
                         c, CacheReq, Done, Stall, c == 0, c == 7, c < 7);
                miscompares++;
            end
            vectors++;
            if (m_rd !== (c >= 1 && c <= 4) || m_wr !== 1'b0 ||
                (m_rd && m_addr !== 16'h0018 + 16'(2 * (c - 1)))) begin
                $display("FAIL cold_mrd cyc %0d: got rd=%b wr=%b addr=%h want rd=%b addr=%h",
                         c, m_rd, m_wr, m_addr, c >= 1 && c <= 4, 16'h0018 + 16'(2 * (c - 1)));
                miscompares++;
            end
            if (c >= 3 && c <= 6) begin
                vectors++;
                if (c_write !== 1'b1 || c_comp !== 1'b0 || c_offset !== 3'(2 * (c - 3)) ||
                    c_data_in !== memInit(16'h0018 + 16'(2 * (c - 3)))) begin
                    $display("FAIL cold_fill cyc %0d: got wr=%b comp=%b off=%0d data=%h want 1 0 %0d %h",
                             c, c_write, c_comp, c_offset, c_data_in, 2 * (c - 3),
                             memInit(16'h0018 + 16'(2 * (c - 3))));
                    miscompares++;
                end
            end
            if (c == 7) begin
                vectors++;
                if (DataOut !== 16'hC342 || CacheHit !== 1'b0) begin
                    $display("FAIL cold_data: got data=%h hit=%b want C342 0", DataOut, CacheHit);
                    miscompares++;
                end
            end
            @(posedge clk); #1;
        end
        Rd = 1'b0;
    endtask

    task automatic test_hits();
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h001A;
        @(negedge clk);
        vectors++;
        if ({Done, CacheHit, CacheReq, Stall, m_rd, m_wr} !== 6'b111000 || DataOut !== 16'hC340) begin
            $display("FAIL hit_read: got flags=%b data=%h want 111000 C340",
                     {Done, CacheHit, CacheReq, Stall, m_rd, m_wr}, DataOut);
            miscompares++;
        end
        @(posedge clk); #1;
        Rd = 1'b0; Wr = 1'b1; Addr = 16'h0018; DataIn = 16'hBEEF;
        @(negedge clk);
        vectors++;
        if ({Done, CacheHit, CacheReq, Stall, m_rd, m_wr, c_write} !== 7'b1110001) begin
            $display("FAIL hit_write: got flags=%b want 1110001",
                     {Done, CacheHit, CacheReq, Stall, m_rd, m_wr, c_write});
            miscompares++;
        end
        @(posedge clk); #1;
        Wr = 1'b0;
        @(negedge clk);
        vectors++;
        if ({Done, CacheHit, CacheReq} !== 3'b000) begin
            $display("FAIL hit_pulse: got %b want 000", {Done, CacheHit, CacheReq});
            miscompares++;
        end
        @(posedge clk); #1;
        Rd = 1'b1; Addr = 16'h0018;
        @(negedge clk);
        vectors++;
        if (Done !== 1'b1 || CacheHit !== 1'b1 || DataOut !== 16'hBEEF) begin
            $display("FAIL hit_readback: got done=%b hit=%b data=%h want 1 1 BEEF",
                     Done, CacheHit, DataOut);
            miscompares++;
        end
        @(posedge clk); #1;
        Rd = 1'b0;
    endtask

    task automatic test_dirty_evict();
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h0818;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            vectors++;
            if (CacheReq !== (c == 0) || Done !== (c == 11) || Stall !== (c < 11) ||
                (m_rd && m_wr)) begin
                $display("FAIL evict_ctrl cyc %0d: got req=%b done=%b stall=%b rdwr=%b%b",
                         c, CacheReq, Done, Stall, m_rd, m_wr);
                miscompares++;
            end
            vectors++;
            if (m_wr !== (c >= 1 && c <= 4) ||
                (m_wr && (m_addr !== 16'h0018 + 16'(2 * (c - 1)) ||
                          m_data_in !== ((c == 1) ? 16'hBEEF : memInit(16'h0018 + 16'(2 * (c - 1))))))) begin
                $display("FAIL evict_mwr cyc %0d: got wr=%b addr=%h data=%h", c, m_wr, m_addr, m_data_in);
                miscompares++;
            end
            vectors++;
            if (m_rd !== (c >= 5 && c <= 8) ||
                (m_rd && m_addr !== 16'h0818 + 16'(2 * (c - 5)))) begin
                $display("FAIL evict_mrd cyc %0d: got rd=%b addr=%h want rd=%b addr=%h",
                         c, m_rd, m_addr, c >= 5 && c <= 8, 16'h0818 + 16'(2 * (c - 5)));
                miscompares++;
            end
            if (c == 11) begin
                vectors++;
                if (DataOut !== 16'hCB42 || CacheHit !== 1'b0) begin
                    $display("FAIL evict_data: got data=%h hit=%b want CB42 0", DataOut, CacheHit);
                    miscompares++;
                end
            end
            @(posedge clk); #1;
        end
        Rd = 1'b0;
        vectors++;
        if (memArr[16'h000C] !== 16'hBEEF) begin
            $display("FAIL evict_mem: got %h want BEEF", memArr[16'h000C]);
            miscompares++;
        end
    endtask

    task automatic test_errors();
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h0019;
        @(negedge clk);
        vectors++;
        if ({Err, Done, CacheReq, Stall, c_enable, m_rd, m_wr} !== 7'b1100000) begin
            $display("FAIL err_odd: got %b want 1100000",
                     {Err, Done, CacheReq, Stall, c_enable, m_rd, m_wr});
            miscompares++;
        end
        @(posedge clk); #1;
        Wr = 1'b1; Addr = 16'h0018;
        @(negedge clk);
        vectors++;
        if ({Err, Done, CacheReq, Stall, c_enable, m_rd, m_wr} !== 7'b1100000) begin
            $display("FAIL err_rdwr: got %b want 1100000",
                     {Err, Done, CacheReq, Stall, c_enable, m_rd, m_wr});
            miscompares++;
        end
        @(posedge clk); #1;
        Rd = 1'b0; Wr = 1'b0;
        @(negedge clk);
        vectors++;
        if ({Err, Done} !== 2'b00) begin
            $display("FAIL err_clear: got %b want 00", {Err, Done});
            miscompares++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wb();
        // make index 3 (tag 1) dirty
        Wr = 1'b1; Addr = 16'h0818; DataIn = 16'h1234;
        @(negedge clk);
        vectors++;
        if (Done !== 1'b1 || CacheHit !== 1'b1) begin
            $display("FAIL rmw_store: got done=%b hit=%b want 1 1", Done, CacheHit);
            miscompares++;
        end
        @(posedge clk); #1;
        Wr = 1'b0; Rd = 1'b1; Addr = 16'h0018;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            if (c == 3) begin
                vectors++;
                if (m_wr !== 1'b1 || m_addr !== 16'h081C) begin
                    $display("FAIL rmw_wb2: got wr=%b addr=%h want 1 081C", m_wr, m_addr);
                    miscompares++;
                end
                #1 rst = 1'b1;
                #1;
                vectors++;
                if ({Stall, m_wr, m_rd, Done, c_enable} !== 5'b00000) begin
                    $display("FAIL rmw_inreset: got %b want 00000", {Stall, m_wr, m_rd, Done, c_enable});
                    miscompares++;
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; Rd = 1'b0;
        @(negedge clk);
        vectors++;
        if ({Stall, m_wr, m_rd, Done} !== 4'b0000) begin
            $display("FAIL rmw_idle: got %b want 0000", {Stall, m_wr, m_rd, Done});
            miscompares++;
        end
        @(posedge clk); #1;
        // reissue: line untouched and still dirty, so a full dirty miss
        Rd = 1'b1; Addr = 16'h0018;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            vectors++;
            if (Done !== (c == 11)) begin
                $display("FAIL reissue_done cyc %0d: got %b want %b", c, Done, c == 11);
                miscompares++;
            end
            if (c == 1) begin
                vectors++;
                if (m_wr !== 1'b1 || m_addr !== 16'h0818 || m_data_in !== 16'h1234) begin
                    $display("FAIL reissue_wb: got wr=%b addr=%h data=%h want 1 0818 1234",
                             m_wr, m_addr, m_data_in);
                    miscompares++;
                end
            end
            if (c == 11) begin
                vectors++;
                if (DataOut !== 16'hBEEF) begin
                    $display("FAIL reissue_data: got %h want BEEF", DataOut);
                    miscompares++;
                end
            end
            @(posedge clk); #1;
        end
        Rd = 1'b0;
        @(posedge clk); #1;
        // back-to-back: tag 1 is now a clean miss returning the written-back word
        Rd = 1'b1; Addr = 16'h0818;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            vectors++;
            if (Done !== (c == 7) || m_wr !== 1'b0) begin
                $display("FAIL clean_ctrl cyc %0d: got done=%b wr=%b want %b 0", c, Done, m_wr, c == 7);
                miscompares++;
            end
            if (c == 7) begin
                vectors++;
                if (DataOut !== 16'h1234) begin
                    $display("FAIL clean_data: got %h want 1234", DataOut);
                    miscompares++;
                end
            end
            @(posedge clk); #1;
        end
        Rd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hits();
        test_dirty_evict();
        test_errors();
        test_reset_mid_wb();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
